// File: rtl/c_piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out unload register.
package c_piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_t;

  // Enable-priority selection shared with the rest of the baseblocks family.
  localparam int c_override    = 0;
  localparam int c_no_override = 1;

  // Ceiling log2, never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/c_piso_cnt_v5_0.sv
// Bit counter for the PISO unload register: saturates at C_WIDTH-1 and flags it.
module c_piso_cnt_v5_0
  import c_piso_pkg::*;
#(
  parameter int C_WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = clog2(C_WIDTH);
  localparam logic [CW-1:0] P_TC = CW'(C_WIDTH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != P_TC)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == P_TC);

endmodule

// File: rtl/c_reg_piso_v5_0.sv
// Parallel-in/serial-out unload register with valid/ready on both sides,
// optional clock enable and synchronous clear, zero-bubble word reloads.
module c_reg_piso_v5_0
  import c_piso_pkg::*;
#(
  parameter int   C_WIDTH       = 16,
  parameter int   C_MSB_FIRST   = 1,
  parameter int   C_HAS_CE      = 0,
  parameter int   C_HAS_SCLR    = 0,
  parameter int   C_SYNC_ENABLE = 0,
  parameter logic C_IDLE_VAL    = 1'b0
) (
  input  logic               CLK,
  input  logic               ACLR_N,
  input  logic               CE,
  input  logic               SCLR,
  input  logic [C_WIDTH-1:0] D,
  input  logic               LD_VALID,
  output logic               LD_READY,
  output logic               SOUT,
  output logic               SOUT_VALID,
  input  logic               SOUT_READY,
  output logic               SOUT_LAST,
  output logic               BUSY
);

  localparam logic P_CE_USED        = (C_HAS_CE != 0);
  localparam logic P_SCLR_USED      = (C_HAS_SCLR != 0);
  localparam logic P_SCLR_NEEDS_CE  = (C_SYNC_ENABLE != c_override);

  piso_state_t        r_state, w_state_nxt;
  logic [C_WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic               w_ce, w_sclr, w_busy, w_xfer, w_load, w_tc;
  logic               w_ld_ready, w_cnt_clr, w_cnt_inc, w_out_bit;

  // Unused CE/SCLR ports are masked rather than dropped so the port list stays fixed.
  assign w_ce   = CE | ~P_CE_USED;
  assign w_sclr = SCLR & P_SCLR_USED & (w_ce | ~P_SCLR_NEEDS_CE);

  assign w_busy     = (r_state == ST_SHIFT);
  assign w_xfer     = w_busy & SOUT_READY & w_ce;
  assign w_ld_ready = w_ce & ~w_sclr & (~w_busy | (w_xfer & w_tc));
  assign w_load     = LD_VALID & w_ld_ready;

  assign w_shifted = (C_MSB_FIRST != 0) ? {r_shift[C_WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[C_WIDTH-1:1]};
  assign w_out_bit = (C_MSB_FIRST != 0) ? r_shift[C_WIDTH-1] : r_shift[0];

  c_piso_cnt_v5_0 #(
    .C_WIDTH (C_WIDTH)
  ) u_cnt (
    .i_clk   (CLK),
    .i_rst_n (ACLR_N),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (w_sclr) begin
      w_state_nxt = ST_IDLE;
      w_shift_nxt = '0;
      w_cnt_clr   = 1'b1;
    end else if (w_load) begin
      // Covers both the idle load and the reload on the final-bit transfer.
      w_state_nxt = ST_SHIFT;
      w_shift_nxt = D;
      w_cnt_clr   = 1'b1;
    end else if (w_xfer) begin
      w_shift_nxt = w_shifted;
      if (w_tc) begin
        w_state_nxt = ST_IDLE;
        w_cnt_clr   = 1'b1;
      end else begin
        w_cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign LD_READY   = w_ld_ready;
  assign BUSY       = w_busy;
  assign SOUT_VALID = w_busy;
  assign SOUT_LAST  = w_busy & w_tc;
  assign SOUT       = w_busy ? w_out_bit : C_IDLE_VAL;

endmodule
